// File: rtl/apb_pkg.sv
// Shared definitions for the peripheral-bus arbiter: FSM state encoding,
// default timeout and peripheral base addresses.
package apb_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETUP  = 2'd1,
    ACCESS = 2'd2,
    DONE   = 2'd3
  } apb_state_e;

  localparam int unsigned APB_TIMEOUT_DEFAULT = 16;
  localparam logic [31:0] UART_BASE           = 32'h1000_0000;

endpackage

// File: rtl/apb_arbiter.sv
// Two-master round-robin arbiter and setup/access sequencer for the pclk
// peripheral bus, with a timeout that turns a silent slave into an error.
module apb_arbiter
  import apb_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH = 32,
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned TIMEOUT    = APB_TIMEOUT_DEFAULT
) (
  input  logic                  pclk,
  input  logic                  reset,
  input  logic                  m0_req,
  input  logic [ADDR_WIDTH-1:0] m0_addr,
  input  logic [DATA_WIDTH-1:0] m0_wdata,
  input  logic                  m0_write,
  input  logic [3:0]            m0_stb,
  output logic [DATA_WIDTH-1:0] m0_rdata,
  output logic                  m0_err,
  output logic                  m0_done,
  input  logic                  m1_req,
  input  logic [ADDR_WIDTH-1:0] m1_addr,
  input  logic [DATA_WIDTH-1:0] m1_wdata,
  input  logic                  m1_write,
  input  logic [3:0]            m1_stb,
  output logic [DATA_WIDTH-1:0] m1_rdata,
  output logic                  m1_err,
  output logic                  m1_done,
  output logic [ADDR_WIDTH-1:0] paddr,
  output logic [DATA_WIDTH-1:0] pdata,
  output logic                  pwrite,
  output logic [3:0]            pstb,
  output logic                  psel,
  output logic                  penable,
  input  logic [DATA_WIDTH-1:0] prdata,
  input  logic                  ready,
  input  logic                  perr,
  output logic                  owner
);

  localparam int unsigned     CW      = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [CW-1:0]   TO_LAST = CW'(TIMEOUT - 1);

  apb_state_e            state_q, state_d;
  logic                  last_grant_q, last_grant_d;
  logic                  owner_q, owner_d;
  logic [ADDR_WIDTH-1:0] paddr_q, paddr_d;
  logic [DATA_WIDTH-1:0] pdata_q, pdata_d;
  logic                  pwrite_q, pwrite_d;
  logic [3:0]            pstb_q, pstb_d;
  logic [CW-1:0]         cnt_q, cnt_d;
  logic [DATA_WIDTH-1:0] m0_rdata_q, m0_rdata_d, m1_rdata_q, m1_rdata_d;
  logic                  m0_err_q, m0_err_d, m1_err_q, m1_err_d;

  logic                  gnt;
  logic                  cap_en;
  logic [DATA_WIDTH-1:0] cap_data;
  logic                  cap_err;

  always_comb begin
    state_d      = state_q;
    last_grant_d = last_grant_q;
    owner_d      = owner_q;
    paddr_d      = paddr_q;
    pdata_d      = pdata_q;
    pwrite_d     = pwrite_q;
    pstb_d       = pstb_q;
    cnt_d        = cnt_q;
    m0_rdata_d   = m0_rdata_q;
    m0_err_d     = m0_err_q;
    m1_rdata_d   = m1_rdata_q;
    m1_err_d     = m1_err_q;
    gnt          = 1'b0;
    cap_en       = 1'b0;
    cap_data     = '0;
    cap_err      = 1'b0;

    case (state_q)
      IDLE: begin
        if (m0_req || m1_req) begin
          // On a tie the master that did not win last time is served.
          gnt          = (m0_req && m1_req) ? ~last_grant_q : m1_req;
          owner_d      = gnt;
          last_grant_d = gnt;
          paddr_d      = gnt ? m1_addr  : m0_addr;
          pdata_d      = gnt ? m1_wdata : m0_wdata;
          pwrite_d     = gnt ? m1_write : m0_write;
          pstb_d       = gnt ? m1_stb   : m0_stb;
          state_d      = SETUP;
        end
      end
      SETUP: begin
        cnt_d   = '0;
        state_d = ACCESS;
      end
      ACCESS: begin
        cnt_d = cnt_q + CW'(1);
        if (ready) begin
          cap_en   = 1'b1;
          cap_data = pwrite_q ? '0 : prdata;
          cap_err  = perr;
          state_d  = DONE;
        end else if (cnt_q == TO_LAST) begin
          cap_en   = 1'b1;
          cap_err  = 1'b1;
          state_d  = DONE;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    if (cap_en) begin
      if (owner_q) begin
        m1_rdata_d = cap_data;
        m1_err_d   = cap_err;
      end else begin
        m0_rdata_d = cap_data;
        m0_err_d   = cap_err;
      end
    end
  end

  always_ff @(posedge pclk) begin
    if (reset) begin
      state_q      <= IDLE;
      last_grant_q <= 1'b1;
      owner_q      <= 1'b0;
      paddr_q      <= '0;
      pdata_q      <= '0;
      pwrite_q     <= 1'b0;
      pstb_q       <= '0;
      cnt_q        <= '0;
      m0_rdata_q   <= '0;
      m0_err_q     <= 1'b0;
      m1_rdata_q   <= '0;
      m1_err_q     <= 1'b0;
    end else begin
      state_q      <= state_d;
      last_grant_q <= last_grant_d;
      owner_q      <= owner_d;
      paddr_q      <= paddr_d;
      pdata_q      <= pdata_d;
      pwrite_q     <= pwrite_d;
      pstb_q       <= pstb_d;
      cnt_q        <= cnt_d;
      m0_rdata_q   <= m0_rdata_d;
      m0_err_q     <= m0_err_d;
      m1_rdata_q   <= m1_rdata_d;
      m1_err_q     <= m1_err_d;
    end
  end

  assign psel     = (state_q == SETUP) || (state_q == ACCESS);
  assign penable  = (state_q == ACCESS);
  assign m0_done  = (state_q == DONE) && !owner_q;
  assign m1_done  = (state_q == DONE) &&  owner_q;
  assign paddr    = paddr_q;
  assign pdata    = pdata_q;
  assign pwrite   = pwrite_q;
  assign pstb     = pstb_q;
  assign owner    = owner_q;
  assign m0_rdata = m0_rdata_q;
  assign m0_err   = m0_err_q;
  assign m1_rdata = m1_rdata_q;
  assign m1_err   = m1_err_q;

endmodule

// File: tb/tb_apb_arbiter.sv
// Directed bench for apb_arbiter: latency, round-robin, timeout, slave
// error and mid-transfer reset against hand-computed expectations.
module tb_apb_arbiter;
  import apb_pkg::*;

  localparam int AW = 32;
  localparam int DW = 32;
  localparam int TO = 16;

  localparam int S_UART  = 0;
  localparam int S_NEVER = 1;
  localparam int S_AT    = 2;

  logic          pclk, reset;
  logic          m0_req, m0_write, m0_err, m0_done;
  logic [AW-1:0] m0_addr;
  logic [DW-1:0] m0_wdata, m0_rdata;
  logic [3:0]    m0_stb;
  logic          m1_req, m1_write, m1_err, m1_done;
  logic [AW-1:0] m1_addr;
  logic [DW-1:0] m1_wdata, m1_rdata;
  logic [3:0]    m1_stb;
  logic [AW-1:0] paddr;
  logic [DW-1:0] pdata, prdata;
  logic          pwrite, psel, penable, ready, perr, owner;
  logic [3:0]    pstb;

  int   checks = 0;
  int   errors = 0;
  int   slave_mode = S_UART;
  int   at_k = 0;
  logic at_perr = 1'b0;
  int   pen_cnt = 0;

  apb_arbiter #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .TIMEOUT(TO)) dut (
    .pclk(pclk), .reset(reset),
    .m0_req(m0_req), .m0_addr(m0_addr), .m0_wdata(m0_wdata), .m0_write(m0_write),
    .m0_stb(m0_stb), .m0_rdata(m0_rdata), .m0_err(m0_err), .m0_done(m0_done),
    .m1_req(m1_req), .m1_addr(m1_addr), .m1_wdata(m1_wdata), .m1_write(m1_write),
    .m1_stb(m1_stb), .m1_rdata(m1_rdata), .m1_err(m1_err), .m1_done(m1_done),
    .paddr(paddr), .pdata(pdata), .pwrite(pwrite), .pstb(pstb),
    .psel(psel), .penable(penable), .prdata(prdata), .ready(ready), .perr(perr),
    .owner(owner)
  );

  initial pclk = 1'b0;
  always #5 pclk = ~pclk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog");
  end

  // Advance one cycle and update the slave model from what it saw before the edge.
  task automatic tick();
    logic pp, r;
    pp = psel && penable;
    r  = ready;
    @(posedge pclk);
    #1;
    case (slave_mode)
      S_UART: begin
        ready = pp && !r;
        perr  = 1'b0;
      end
      S_AT: begin
        if (psel && penable) pen_cnt++;
        else pen_cnt = 0;
        ready = psel && penable && (pen_cnt == at_k);
        perr  = ready ? at_perr : 1'b0;
      end
      default: begin
        ready = 1'b0;
        perr  = 1'b0;
      end
    endcase
  endtask

  task automatic do_reset();
    reset = 1'b1;
    m0_req = 1'b0;
    m1_req = 1'b0;
    ready = 1'b0;
    perr = 1'b0;
    tick();
    tick();
    reset = 1'b0;
  endtask

  task automatic test_reset();
    m0_addr = '0; m0_wdata = '0; m0_write = 1'b0; m0_stb = '0;
    m1_addr = '0; m1_wdata = '0; m1_write = 1'b0; m1_stb = '0;
    prdata = '0;
    do_reset();
    checks++;
    if ({psel, penable, pwrite, pstb, m0_done, m1_done, m0_err, m1_err, owner} !== 13'b0) begin
      errors++;
      $display("FAIL reset_ctrl: got %b expected 0",
               {psel, penable, pwrite, pstb, m0_done, m1_done, m0_err, m1_err, owner});
    end
    checks++;
    if ({paddr, pdata, m0_rdata, m1_rdata} !== 128'b0) begin
      errors++;
      $display("FAIL reset_data: got %h %h %h %h expected 0", paddr, pdata, m0_rdata, m1_rdata);
    end
  endtask

  task automatic test_write_m0();
    logic seen_m1;
    seen_m1 = 1'b0;
    slave_mode = S_UART;
    prdata = 32'hDEAD_BEEF;
    m0_addr = UART_BASE; m0_wdata = 32'h41; m0_write = 1'b1; m0_stb = 4'b0001;
    m0_req = 1'b1;
    tick();
    seen_m1 |= m1_done;
    checks++;
    if ({psel, penable, m0_done} !== 3'b100) begin
      errors++;
      $display("FAIL write_setup: got %b expected 100", {psel, penable, m0_done});
    end
    checks++;
    if ({paddr, pdata, pwrite, pstb} !== {UART_BASE, 32'h41, 1'b1, 4'b0001}) begin
      errors++;
      $display("FAIL write_bus: got %h %h %b %b expected 10000000 00000041 1 0001",
               paddr, pdata, pwrite, pstb);
    end
    for (int c = 2; c <= 3; c++) begin
      tick();
      seen_m1 |= m1_done;
      checks++;
      if ({psel, penable, m0_done} !== 3'b110) begin
        errors++;
        $display("FAIL write_access_n%0d: got %b expected 110", c, {psel, penable, m0_done});
      end
    end
    tick();
    seen_m1 |= m1_done;
    checks++;
    if ({psel, penable, m0_done, m0_err, m0_rdata} !== {4'b0010, 32'h0}) begin
      errors++;
      $display("FAIL write_done: got %b %b %b %b %h expected 0 0 1 0 00000000",
               psel, penable, m0_done, m0_err, m0_rdata);
    end
    m0_req = 1'b0;
    tick();
    seen_m1 |= m1_done;
    checks++;
    if ({m0_done, seen_m1, psel} !== 3'b000) begin
      errors++;
      $display("FAIL write_after: got %b expected 000", {m0_done, seen_m1, psel});
    end
  endtask

  task automatic test_read_m1();
    int cyc;
    logic done_seen;
    slave_mode = S_UART;
    prdata = 32'h60;
    m1_addr = UART_BASE + 32'h5; m1_wdata = 32'h0; m1_write = 1'b0; m1_stb = 4'hF;
    m1_req = 1'b1;
    cyc = 0;
    done_seen = 1'b0;
    for (int i = 0; i < 50; i++) begin
      tick();
      cyc++;
      if (m0_done || m1_done) begin
        done_seen = 1'b1;
        break;
      end
    end
    checks++;
    if (!done_seen) begin
      errors++;
      $display("FAIL read_m1_wait: got no done expected done within 50 cycles");
    end
    checks++;
    if ({m1_done, m0_done, owner, m1_err} !== 4'b1010 || m1_rdata !== 32'h60 || cyc != 4) begin
      errors++;
      $display("FAIL read_m1: got done=%b%b owner=%b err=%b rdata=%h cyc=%0d expected 10 1 0 00000060 4",
               m1_done, m0_done, owner, m1_err, m1_rdata, cyc);
    end
    checks++;
    if (paddr !== 32'h1000_0005 || pwrite !== 1'b0 || m0_rdata !== 32'h0) begin
      errors++;
      $display("FAIL read_m1_bus: got paddr=%h pwrite=%b m0_rdata=%h expected 10000005 0 00000000",
               paddr, pwrite, m0_rdata);
    end
    m1_req = 1'b0;
    tick();
  endtask

  task automatic test_round_robin();
    int cyc, who, exp_who, exp_cyc;
    logic done_seen;
    logic [DW-1:0] prev [2];
    do_reset();
    checks++;
    if (owner !== 1'b0 || m1_rdata !== 32'h0) begin
      errors++;
      $display("FAIL rr_reset: got owner=%b m1_rdata=%h expected 0 00000000", owner, m1_rdata);
    end
    prev[0] = '0;
    prev[1] = '0;
    slave_mode = S_UART;
    m0_addr = UART_BASE + 32'h1; m0_write = 1'b0; m0_stb = 4'hF;
    m1_addr = UART_BASE + 32'h2; m1_write = 1'b0; m1_stb = 4'hF;
    m0_req = 1'b1;
    m1_req = 1'b1;
    for (int k = 0; k < 6; k++) begin
      prdata = 32'h100 + k;
      exp_who = k % 2;
      exp_cyc = (k == 0) ? 4 : 5;
      cyc = 0;
      done_seen = 1'b0;
      for (int i = 0; i < 50; i++) begin
        tick();
        cyc++;
        if (m0_done || m1_done) begin
          done_seen = 1'b1;
          break;
        end
      end
      who = m1_done ? 1 : 0;
      checks++;
      if (!done_seen || (m0_done && m1_done) || who != exp_who || owner !== exp_who[0] ||
          cyc != exp_cyc) begin
        errors++;
        $display("FAIL rr_grant_%0d: got done=%b who=%0d owner=%b cyc=%0d expected master %0d cyc %0d",
                 k, done_seen, who, owner, cyc, exp_who, exp_cyc);
      end
      checks++;
      if ((exp_who == 0 && (m0_rdata !== 32'h100 + k || m1_rdata !== prev[1])) ||
          (exp_who == 1 && (m1_rdata !== 32'h100 + k || m0_rdata !== prev[0]))) begin
        errors++;
        $display("FAIL rr_data_%0d: got m0=%h m1=%h expected winner %0d data %h, other holding",
                 k, m0_rdata, m1_rdata, exp_who, 32'h100 + k);
      end
      prev[exp_who] = 32'h100 + k;
    end
    m0_req = 1'b0;
    m1_req = 1'b0;
    tick();
  endtask

  task automatic test_timeout();
    int pen;
    logic done_seen;
    slave_mode = S_NEVER;
    prdata = 32'hFFFF_FFFF;
    m0_addr = UART_BASE + 32'h20; m0_write = 1'b0; m0_stb = 4'hF;
    m0_req = 1'b1;
    pen = 0;
    done_seen = 1'b0;
    for (int i = 0; i < 60; i++) begin
      tick();
      if (penable) pen++;
      if (m0_done) begin
        done_seen = 1'b1;
        break;
      end
    end
    checks++;
    if (!done_seen || pen != TO || m0_err !== 1'b1 || m0_rdata !== 32'h0 || m1_done !== 1'b0) begin
      errors++;
      $display("FAIL timeout: got done=%b penable_cycles=%0d err=%b rdata=%h expected 1 %0d 1 00000000",
               done_seen, pen, m0_err, m0_rdata, TO);
    end
    checks++;
    if (m1_rdata !== 32'h105 || m1_err !== 1'b0) begin
      errors++;
      $display("FAIL timeout_hold: got m1_rdata=%h m1_err=%b expected 00000105 0", m1_rdata, m1_err);
    end
    m0_req = 1'b0;
    tick();
  endtask

  task automatic test_slave_error();
    int            k_tab   [3] = '{TO, TO, 3};
    logic          perr_tab[3] = '{1'b1, 1'b0, 1'b1};
    logic [DW-1:0] data_tab[3] = '{32'h77, 32'h88, 32'h99};
    int pen;
    logic done_seen;
    slave_mode = S_AT;
    m1_addr = UART_BASE + 32'h8; m1_write = 1'b0; m1_stb = 4'hF;
    for (int t = 0; t < 3; t++) begin
      at_k = k_tab[t];
      at_perr = perr_tab[t];
      prdata = data_tab[t];
      m1_req = 1'b1;
      pen = 0;
      done_seen = 1'b0;
      for (int i = 0; i < 60; i++) begin
        tick();
        if (penable) pen++;
        if (m1_done) begin
          done_seen = 1'b1;
          break;
        end
      end
      checks++;
      if (!done_seen || pen != k_tab[t] || m1_err !== perr_tab[t] || m1_rdata !== data_tab[t]) begin
        errors++;
        $display("FAIL slave_err_%0d: got done=%b penable_cycles=%0d err=%b rdata=%h expected 1 %0d %b %h",
                 t, done_seen, pen, m1_err, m1_rdata, k_tab[t], perr_tab[t], data_tab[t]);
      end
      m1_req = 1'b0;
      tick();
    end
  endtask

  task automatic test_reset_access();
    logic any_done;
    any_done = 1'b0;
    slave_mode = S_NEVER;
    m0_addr = UART_BASE + 32'h4; m0_write = 1'b0; m0_stb = 4'hF;
    m0_req = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      any_done |= m0_done | m1_done;
    end
    checks++;
    if ({psel, penable} !== 2'b11) begin
      errors++;
      $display("FAIL rst_acc_pre: got %b expected 11", {psel, penable});
    end
    reset = 1'b1;
    tick();
    reset = 1'b0;
    any_done |= m0_done | m1_done;
    checks++;
    if ({psel, penable, any_done} !== 3'b000) begin
      errors++;
      $display("FAIL rst_acc_abandon: got %b expected 000", {psel, penable, any_done});
    end
    tick();
    any_done |= m0_done | m1_done;
    checks++;
    if ({psel, penable, any_done, owner} !== 4'b1000 || paddr !== UART_BASE + 32'h4) begin
      errors++;
      $display("FAIL rst_acc_restart: got %b paddr=%h expected 1000 10000004",
               {psel, penable, any_done, owner}, paddr);
    end
    do_reset();
  endtask

  initial begin
    reset = 1'b1;
    m0_req = 1'b0;
    m1_req = 1'b0;
    ready = 1'b0;
    perr = 1'b0;
    test_reset();
    test_write_m0();
    test_read_m1();
    test_round_robin();
    test_timeout();
    test_slave_error();
    test_reset_access();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
